shl_seq_unit: RTL and testbench



---
 rtl/shl_seq_unit_pkg.sv | 22 ++
 rtl/shl1_comb.sv | 25 ++
 rtl/shl_seq_unit.sv | 142 ++++++++++++++
 tb/tb_shl_seq_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shl_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shl_seq_unit_pkg
// Description : Shared state encoding and default widths for the sequential
//               left shifter and its combinational shift-by-one stage.
// Revision    : 1.0 - initial release
// ============================================================================
package shl_seq_unit_pkg;

  // Default operand width and shift-count width (count must hold up to W).
  localparam int SHL_W  = 8;
  localparam int SHL_CW = 4;

  // FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : shl_seq_unit_pkg
`default_nettype wire

// File: rtl/shl1_comb.sv
`default_nettype none
// ============================================================================
// Module      : shl1_comb
// Description : Purely combinational shift-left-by-one stage. The vacated LSB
//               is filled with 0 and the bit leaving the MSB is the carry.
// Revision    : 1.0 - initial release
// ============================================================================
module shl1_comb
  import shl_seq_unit_pkg::*;
#(
  parameter int W = SHL_W
) (
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_carry
);

  // Shift by one and expose the outgoing MSB.
  always_comb begin
    o_data  = {i_data[W-2:0], 1'b0};
    o_carry = i_data[W-1];
  end

endmodule : shl1_comb
`default_nettype wire

// File: rtl/shl_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : shl_seq_unit
// Description : Sequential multi-bit left shifter. One accepted start shifts
//               the captured operand left by min(n, W) positions, one per
//               clock, streaming each outgoing MSB on sout and ending with a
//               one-cycle done pulse. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module shl_seq_unit
  import shl_seq_unit_pkg::*;
#(
  parameter int W  = SHL_W,
  parameter int CW = SHL_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x,
  input  logic [CW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  f,
  output logic          cout,
  output logic          sout,
  output logic          sout_valid
);

  localparam logic [CW-1:0] C_CNT_MAX = CW'(W);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_data;
  logic [W-1:0]  w_data_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_cout;
  logic          w_cout_nxt;
  logic          r_sout;
  logic          w_sout_nxt;
  logic          r_sout_valid;
  logic          w_sout_valid_nxt;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0] w_n_clamped;
  logic [W-1:0]  w_shl_data;
  logic          w_shl_carry;

  // Single-position shift of the working register.
  shl1_comb #(
    .W (W)
  ) u_shl1 (
    .i_data  (r_data),
    .o_data  (w_shl_data),
    .o_carry (w_shl_carry)
  );

  // Shift amounts beyond the width behave as a full-width shift.
  always_comb begin
    w_n_clamped = (n > C_CNT_MAX) ? C_CNT_MAX : n;
  end

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    w_state_nxt      = r_state;
    w_data_nxt       = r_data;
    w_cnt_nxt        = r_cnt;
    w_cout_nxt       = r_cout;
    w_sout_nxt       = r_sout;
    w_sout_valid_nxt = r_sout_valid;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_data_nxt  = x;
          w_cnt_nxt   = w_n_clamped;
          w_cout_nxt  = 1'b0;
          w_state_nxt = (w_n_clamped == '0) ? S_DONE : S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_data_nxt       = w_shl_data;
        w_cout_nxt       = w_shl_carry;
        w_sout_nxt       = w_shl_carry;
        w_sout_valid_nxt = 1'b1;
        w_cnt_nxt        = r_cnt - C_CNT_ONE;
        if (r_cnt == C_CNT_ONE) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_sout_valid_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
      end

      default: begin
        w_sout_valid_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_cnt        <= '0;
      r_cout       <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_data       <= w_data_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cout       <= w_cout_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // Drive ports straight from registers.
  always_comb begin
    busy       = r_busy;
    done       = r_done;
    f          = r_data;
    cout       = r_cout;
    sout       = r_sout;
    sout_valid = r_sout_valid;
  end

endmodule : shl_seq_unit
`default_nettype wire

// File: tb/tb_shl_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_shl_seq_unit
// Description : Directed self-checking bench for shl_seq_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shl_seq_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [3:0] n;
  logic       busy;
  logic       done;
  logic [7:0] f;
  logic       cout;
  logic       sout;
  logic       sout_valid;

  int checks;
  int failures;

  shl_seq_unit #(
    .W  (8),
    .CW (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x          (x),
    .n          (n),
    .busy       (busy),
    .done       (done),
    .f          (f),
    .cout       (cout),
    .sout       (sout),
    .sout_valid (sout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start and record what the DUT shows, sampling 1 time unit after
  // each rising edge. t=0 is the sample right after the accept edge. Returns
  // one cycle after done (an IDLE cycle) or after a 20-cycle bound.
  task automatic do_op(input logic [7:0] xv, input logic [3:0] nv,
                       output logic [7:0] sq, output int nvalid,
                       output int done_t, output int busy_cnt,
                       output int first_valid_t,
                       output logic [7:0] fv, output logic cv);
    @(negedge clk);
    x = xv; n = nv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sq = '0; nvalid = 0; done_t = -1; busy_cnt = 0; first_valid_t = -1;
    fv = 8'hxx; cv = 1'bx;
    for (int t = 0; t < 20; t++) begin
      if (busy) busy_cnt++;
      if (sout_valid) begin
        if (first_valid_t < 0) first_valid_t = t;
        sq = {sq[6:0], sout};
        nvalid++;
      end
      if (done) begin
        done_t = t; fv = f; cv = cout;
      end
      @(posedge clk); #1;
      if (done_t >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; x = 8'hFF; n = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, f, cout, sout, sout_valid} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, f, cout, sout, sout_valid});
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, f, cout, sout, sout_valid} !== 13'd0) begin
      failures++;
      $display("FAIL idle_after_reset got=%h want=0", {busy, done, f, cout, sout, sout_valid});
    end
  endtask

  task automatic test_n1();
    logic [7:0] sq, fv; logic cv; int nv, dt, bc, fvt;
    do_op(8'h81, 4'd1, sq, nv, dt, bc, fvt, fv, cv);
    checks++;
    if (nv !== 1 || sq !== 8'h01 || fvt !== 1) begin
      failures++;
      $display("FAIL n1_sout got cnt=%0d seq=%h first=%0d want cnt=1 seq=01 first=1", nv, sq, fvt);
    end
    checks++;
    if (dt !== 1 || bc !== 2) begin
      failures++;
      $display("FAIL n1_timing got done_t=%0d busy=%0d want done_t=1 busy=2", dt, bc);
    end
    checks++;
    if (fv !== 8'h02 || cv !== 1'b1) begin
      failures++;
      $display("FAIL n1_result got f=%h cout=%b want f=02 cout=1", fv, cv);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sout_valid !== 1'b0) begin
      failures++;
      $display("FAIL n1_idle got busy=%b done=%b sv=%b want 0 0 0", busy, done, sout_valid);
    end
  endtask

  task automatic test_n3();
    logic [7:0] sq, fv; logic cv; int nv, dt, bc, fvt;
    do_op(8'hA5, 4'd3, sq, nv, dt, bc, fvt, fv, cv);
    checks++;
    if (nv !== 3 || sq !== 8'h05 || fvt !== 1) begin
      failures++;
      $display("FAIL n3_sout got cnt=%0d seq=%h first=%0d want cnt=3 seq=05 first=1", nv, sq, fvt);
    end
    checks++;
    if (dt !== 3 || fv !== 8'h28 || cv !== 1'b1) begin
      failures++;
      $display("FAIL n3_result got done_t=%0d f=%h cout=%b want 3 28 1", dt, fv, cv);
    end
    // Result and last outgoing bit must hold while idling.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (f !== 8'h28 || cout !== 1'b1 || sout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL n3_hold got f=%h cout=%b sout=%b busy=%b want 28 1 1 0", f, cout, sout, busy);
    end
  endtask

  task automatic test_n0();
    logic [7:0] sq, fv; logic cv; int nv, dt, bc, fvt;
    do_op(8'h3C, 4'd0, sq, nv, dt, bc, fvt, fv, cv);
    checks++;
    if (dt !== 0 || bc !== 1 || nv !== 0) begin
      failures++;
      $display("FAIL n0_timing got done_t=%0d busy=%0d valid=%0d want 0 1 0", dt, bc, nv);
    end
    checks++;
    if (fv !== 8'h3C || cv !== 1'b0) begin
      failures++;
      $display("FAIL n0_result got f=%h cout=%b want 3c 0", fv, cv);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] sq, fv; logic cv; int nv, dt, bc, fvt;
    do_op(8'h01, 4'd12, sq, nv, dt, bc, fvt, fv, cv);
    checks++;
    if (nv !== 8 || sq !== 8'h01 || dt !== 8) begin
      failures++;
      $display("FAIL clamp_sout got cnt=%0d seq=%h done_t=%0d want 8 01 8", nv, sq, dt);
    end
    checks++;
    if (fv !== 8'h00 || cv !== 1'b1) begin
      failures++;
      $display("FAIL clamp_result got f=%h cout=%b want 00 1", fv, cv);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sq, fv; logic cv; int nv, dt, bc, fvt;
    do_op(8'h81, 4'd1, sq, nv, dt, bc, fvt, fv, cv);
    // Next start lands in the IDLE cycle right after DONE.
    do_op(8'hC3, 4'd2, sq, nv, dt, bc, fvt, fv, cv);
    checks++;
    if (nv !== 2 || sq !== 8'h03 || dt !== 2 || fv !== 8'h0C || cv !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back got cnt=%0d seq=%h done_t=%0d f=%h cout=%b want 2 03 2 0c 1",
               nv, sq, dt, fv, cv);
    end
  endtask

  task automatic test_start_while_busy();
    int dt; int ndone; logic [7:0] fv; logic cv;
    @(negedge clk);
    x = 8'hFF; n = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dt = -1; ndone = 0; fv = 8'hxx; cv = 1'bx;
    for (int t = 0; t < 15; t++) begin
      if (done) begin
        ndone++;
        if (dt < 0) begin dt = t; fv = f; cv = cout; end
      end
      @(negedge clk);
      if (t == 1 || t == 2) begin
        x = 8'h00; n = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dt !== 5 || ndone !== 1 || fv !== 8'hE0 || cv !== 1'b1) begin
      failures++;
      $display("FAIL start_while_busy got done_t=%0d ndone=%0d f=%h cout=%b want 5 1 e0 1",
               dt, ndone, fv, cv);
    end
  endtask

  task automatic test_reset_mid_shift();
    int ndone;
    @(negedge clk);
    x = 8'hFF; n = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    // Two shift edges, then reset rides on the third.
    repeat (2) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (sout !== 1'b1 || sout_valid !== 1'b1 || f !== 8'hFC) begin
      failures++;
      $display("FAIL pre_reset_shift got sout=%b sv=%b f=%h want 1 1 fc", sout, sout_valid, f);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, f, cout, sout, sout_valid} !== 13'd0) begin
      failures++;
      $display("FAIL mid_shift_reset got=%h want=0", {busy, done, f, cout, sout, sout_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL abandoned_op got done_or_busy_cycles=%0d want 0", ndone);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start = 1'b0; x = '0; n = '0;
    test_reset();
    test_n1();
    test_n3();
    test_n0();
    test_clamp();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shl_seq_unit
`default_nettype wire
